circuit_result_collector: RTL and testbench
===========================================

# circuit_result_collector

Downstream result stage for the `circuit_4` datapath. It tracks the fixed two-register latency from operand launch to the registered `z`/`x` outputs, and captures each valid result pair into a small FIFO. It presents the buffered pairs to the consumer over a valid/ready handshake, so the datapath can be launched every cycle without back-pressure logic of its own.

## Interface
Parameters:
- `DW`, 64, datapath width of `circuit_4`; `z` and `x` are `DW/2` bits each.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `LAT`, 2, cycles from the `launch` sample to `z`/`x` being valid; matches `circuit_4`.

Ports:
- `Clk`, in, 1, single clock, rising edge.
- `Rst`, in, 1, reset; asynchronous, active-high.
- `launch`, in, 1, operands `a`/`b`/`c` presented to `circuit_4` this cycle are a real sample.
- `z`, in, DW/2, `circuit_4` output `z`.
- `x`, in, DW/2, `circuit_4` output `x`.
- `out_valid`, out, 1, `out_data` holds a buffered result.
- `out_ready`, in, 1, consumer accepts `out_data` this cycle.
- `out_data`, out, DW, `{z, x}`, with `z` in the upper half.
- `count`, out, log2(DEPTH)+1, current FIFO occupancy.
- `overflow`, out, 1, sticky; a result was dropped.
- `drop_cnt`, out, 16, dropped-result counter. Present only with `RC_DROP_CNT_EN`.

## Operation
- **Latency tracker:** `LAT`-bit shift register `lat_sr`.
  - `lat_sr[0] <= launch`; `lat_sr[i] <= lat_sr[i-1]`.
  - `push = lat_sr[LAT-1]`.
  - On `push`, the current `{z, x}` is the result of the launch made `LAT` edges earlier.
- **FIFO:**
  - Circular buffer with `rd_ptr`/`wr_ptr` of log2(DEPTH) bits; pointers wrap modulo `DEPTH`.
  - Occupancy is held in `count`.
  - Show-ahead: `out_data = mem[rd_ptr]`, `out_valid = (count != 0)`.
- **Pop:** `pop = out_valid & out_ready`. Advances `rd_ptr` and decrements `count`.
- **Push accepted:** when `count < DEPTH`, or when `count == DEPTH` and `pop` is asserted in the same cycle (write to the freed slot).
- **Push dropped:** when `count == DEPTH` and no `pop`.
  - Data is discarded; pointers and `count` are unchanged.
  - `overflow` is set and held until reset.
- **Simultaneous accepted push and pop:** `count` is unchanged and both pointers advance.
- **Pop when empty:** impossible, because `out_valid` is 0.
- **`out_ready` while `out_valid` is 0:** ignored.
- **Result data:** passed through unmodified; no arithmetic.

## Timing
- **Reset values** (all asynchronous on `Rst`):
  - `lat_sr`, both pointers and `count` = 0.
  - `out_valid` = 0 and `overflow` = 0.
  - `drop_cnt` = 0 when compiled in.
  - FIFO contents are not reset; `out_data` is don't-care while `out_valid` = 0.
- **Launch to output:** `launch` high in cycle k.
  - `push` is high in cycle k+2.
  - The entry is written at the end of cycle k+2.
  - `out_valid` rises in cycle k+3 if the FIFO was empty (3 cycles from launch).
- **Throughput:** one launch per cycle is sustained with zero loss while `out_ready` stays high.
- **Handshake:**
  - `out_data` is stable while `out_valid` = 1 and `out_ready` = 0.
  - The transfer completes on the edge where both are high; the next entry, if any, is presented in the following cycle.
- **Reset mid-operation:** in-flight launches in `lat_sr` and all buffered entries are lost. `circuit_4` is reset by the same `Rst`.

## Configuration
- **`RC_DROP_CNT_EN` defined:**
  - `drop_cnt` port exists.
  - It increments on every dropped push and saturates at 16'hFFFF.
- **`RC_DROP_CNT_EN` undefined:**
  - `drop_cnt` port and counter are absent.
  - Only the sticky `overflow` flag reports loss.
  - All other behaviour is identical.

## Test plan
- **Reset:** assert `Rst` asynchronously mid-cycle → `out_valid` = 0, `count` = 0 and `overflow` = 0 immediately, before the next edge.
- **Single launch:** DW=64, `a`=5, `b`=3, `c`=1 with `launch`=1 for one cycle and `out_ready`=1 → `out_valid` is high for exactly one cycle, 3 cycles later. `out_data` equals `{z, x}` as computed by the `circuit_4` model.
- **Streaming:** 10 back-to-back launches with `out_ready`=1 → 10 results in launch order, with no gaps after the first. `overflow` = 0.
- **Back-pressure:** `out_ready`=0 with 6 launches and DEPTH=4 → `count` = 4, `overflow` = 1 and `drop_cnt` = 2. Then raise `out_ready` → the first 4 results drain in order.
- **Full with simultaneous pop:** FIFO full, `out_ready`=1 in the same cycle as `push` → no drop, `count` stays 4, and the new entry appears last.
- **Reset during traffic:** pulse `Rst` with 2 entries buffered and 2 in flight → nothing emerges afterwards. A fresh launch yields exactly one result with the correct 3-cycle latency.

Source files
------------

// File: rtl/circuit_result_collector.sv
// circuit_result_collector: latency-tracked capture of circuit_4 {z,x} results into a show-ahead FIFO.
// Optional RC_DROP_CNT_EN adds a saturating 16-bit dropped-result counter port.
module circuit_result_collector #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     launch,
    input  logic [DW/2-1:0]          z,
    input  logic [DW/2-1:0]          x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef RC_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [LAT-1:0] lat_sr;
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [DW-1:0]  mem [DEPTH];
    logic           push, pop, full, wr_en, drop;
    assign push      = lat_sr[LAT-1];
    assign out_valid = count != '0;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign full      = count == CW'(DEPTH);
    // a full FIFO still accepts when the head leaves on the same edge
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            lat_sr   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            lat_sr[0] <= launch;
            for (int i = 1; i < LAT; i++) lat_sr[i] <= lat_sr[i-1];
            rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr   <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
            count    <= count + CW'(wr_en) - CW'(pop);
            overflow <= overflow | drop;
        end
    end
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr] <= {z, x};
    end
`ifdef RC_DROP_CNT_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_circuit_result_collector.sv
// tb_circuit_result_collector: randomized bench with a queue-based reference of launch latency and FIFO.
module tb_circuit_result_collector;
    localparam int DW = 64, DEPTH = 4, LAT = 2, CW = $clog2(DEPTH) + 1;
    logic Clk = 0, Rst = 0, launch = 0, out_ready = 0;
    logic [DW/2-1:0] z = '0, x = '0;
    logic out_valid, overflow;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
`ifdef RC_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif
    circuit_result_collector #(.DW(DW), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .launch(launch), .z(z), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .overflow(overflow)
`ifdef RC_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );
    always #5 Clk = ~Clk;
    typedef struct { int due; logic [DW-1:0] v; } ent_t;
    ent_t inflight[$];
    logic [DW-1:0] mq[$];
    bit ovf;
    int drops, cyc, vectors, miscompares, rx, last_rx_cyc, first_rx_cyc;

    task automatic step(input bit l, input bit r);
        bit push, pop;
        logic [DW-1:0] pv;
        launch = l;
        out_ready = r;
        push = 0;
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
            pv = inflight[0].v;
            inflight.pop_front();
            push = 1;
        end else pv = {$urandom, $urandom};
        z = pv[DW-1:DW/2];
        x = pv[DW/2-1:0];
        if (l) inflight.push_back('{cyc + LAT, {$urandom, $urandom}});
        #3;
        vectors++;
        if (out_valid !== (mq.size() != 0)) begin
            miscompares++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, mq.size() != 0);
        end
        vectors++;
        if (int'(count) != mq.size() || $isunknown(count)) begin
            miscompares++;
            $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size());
        end
        vectors++;
        if (overflow !== ovf) begin
            miscompares++;
            $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, ovf);
        end
        if (mq.size() != 0) begin
            vectors++;
            if (out_data !== mq[0]) begin
                miscompares++;
                $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, mq[0]);
            end
        end
`ifdef RC_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 16'(drops > 65535 ? 65535 : drops)) begin
            miscompares++;
            $display("FAIL drop_cnt cyc=%0d got=%0d exp=%0d", cyc, drop_cnt, drops);
        end
`endif
        pop = (mq.size() != 0) && r;
        if (pop) begin
            void'(mq.pop_front());
            if (rx == 0 || last_rx_cyc != cyc - 1) first_rx_cyc = cyc;
            rx++;
            last_rx_cyc = cyc;
        end
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(pv);
            else begin
                ovf = 1;
                drops++;
            end
        end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic async_reset();
        launch = 0;
        out_ready = 0;
        #2 Rst = 1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got valid=%b count=%0d ovf=%b exp 0/0/0", out_valid, count, overflow);
        end
        @(posedge Clk);
        #1;
        Rst = 0;
        cyc++;
        inflight.delete();
        mq.delete();
        ovf = 0;
        drops = 0;
    endtask

    task automatic test_reset();
        @(posedge Clk);
        #1;
        async_reset();
        step(0, 0);
    endtask

    task automatic test_single();
        int l0, r0;
        l0 = cyc;
        r0 = rx;
        step(1, 1);
        for (int i = 0; i < 6; i++) step(0, 1);
        vectors++;
        if (rx - r0 != 1 || last_rx_cyc != l0 + 3) begin
            miscompares++;
            $display("FAIL single_latency got n=%0d at=%0d exp n=1 at=%0d", rx - r0, last_rx_cyc, l0 + 3);
        end
    endtask

    task automatic test_streaming();
        int r0;
        r0 = rx;
        for (int i = 0; i < 10; i++) step(1, 1);
        for (int i = 0; i < 5; i++) step(0, 1);
        vectors++;
        if (rx - r0 != 10 || last_rx_cyc - first_rx_cyc != 9 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL streaming got n=%0d span=%0d ovf=%b exp n=10 span=9 ovf=0",
                     rx - r0, last_rx_cyc - first_rx_cyc, overflow);
        end
    endtask

    task automatic test_backpressure();
        int r0;
        for (int i = 0; i < 6; i++) step(1, 0);
        for (int i = 0; i < 3; i++) step(0, 0);
        vectors++;
        if (count !== CW'(4) || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure got count=%0d ovf=%b exp count=4 ovf=1", count, overflow);
        end
`ifdef RC_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL bp_drop_cnt got=%0d exp=2", drop_cnt);
        end
`endif
        r0 = rx;
        for (int i = 0; i < 6; i++) step(0, 1);
        vectors++;
        if (rx - r0 != 4) begin
            miscompares++;
            $display("FAIL bp_drain got=%0d exp=4", rx - r0);
        end
    endtask

    task automatic test_full_pop();
        bit ls [10] = '{1, 1, 1, 1, 0, 0, 1, 0, 0, 0};
        bit rs [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int d0;
        d0 = drops;
        for (int i = 0; i < 10; i++) begin
            step(ls[i], rs[i]);
            if (i == 8) begin
                vectors++;
                if (count !== CW'(4)) begin
                    miscompares++;
                    $display("FAIL full_pop_count got=%0d exp=4", count);
                end
            end
        end
        vectors++;
        if (drops != d0) begin
            miscompares++;
            $display("FAIL full_pop_drop model dropped %0d exp 0", drops - d0);
        end
        for (int i = 0; i < 6; i++) step(0, 1);
    endtask

    task automatic test_reset_traffic();
        int r0, l0;
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        step(1, 0);
        async_reset();
        r0 = rx;
        for (int i = 0; i < 6; i++) step(0, 1);
        vectors++;
        if (rx != r0) begin
            miscompares++;
            $display("FAIL reset_flush got=%0d exp=0", rx - r0);
        end
        l0 = cyc;
        step(1, 1);
        for (int i = 0; i < 6; i++) step(0, 1);
        vectors++;
        if (rx - r0 != 1 || last_rx_cyc != l0 + 3) begin
            miscompares++;
            $display("FAIL reset_relaunch got n=%0d at=%0d exp n=1 at=%0d", rx - r0, last_rx_cyc, l0 + 3);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), (i % 80) < 40 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 8; i++) step(0, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_full_pop();
        test_reset_traffic();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
